// File: rtl/rv32_pkg.sv
// ============================================================================
// rv32_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the RV32 register file and the instruction-decode
// stage that drives it: data width, architectural register count, register
// index width, the dump-stream FSM state encoding and a range-check helper.
// ============================================================================
package rv32_pkg;

    localparam int XLEN    = 32;  // data width
    localparam int REG_CNT = 32;  // number of architectural registers
    localparam int REG_AW  = 5;   // register index width (dump_idx)
    localparam int ADDR_W  = 32;  // width of the address buses from ID

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SCAN = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

    // True when a full-width address selects an implemented register.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       count);
        return (addr < count);
    endfunction

endpackage

// File: rtl/reg_dump_fsm.sv
// ============================================================================
// reg_dump_fsm
// ----------------------------------------------------------------------------
// Sequencer for the full-register dump stream.  On a dump request it walks
// the register index from 0 to REG_CNT-1, presenting one index per accepted
// beat (valid/ready handshake), then pulses dump_done_o for one cycle.
// Requests arriving while a dump is in progress are ignored.
//
// Ports
//   clk           : clock, all state changes on the rising edge
//   reset_n       : synchronous active-low reset
//   dump_req_i    : start a dump (honoured only in IDLE)
//   dump_ready_i  : consumer accepts the presented beat
//   dump_valid_o  : a beat is presented (registered)
//   dump_idx_o    : index of the presented register (registered)
//   dump_done_o   : one-cycle pulse after the last beat is accepted
// ============================================================================
module reg_dump_fsm
    import rv32_pkg::*;
#(
    parameter int REG_CNT = rv32_pkg::REG_CNT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dump_req_i,
    input  logic              dump_ready_i,
    output logic              dump_valid_o,
    output logic [REG_AW-1:0] dump_idx_o,
    output logic              dump_done_o
);

    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(REG_CNT - 1);

    dump_state_e       state_q;
    logic [REG_AW-1:0] idx_q;
    logic              valid_q;
    logic              done_q;

    // NOTE: every register here is updated with <= so all of them see the
    // values from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                DUMP_IDLE: begin
                    done_q <= 1'b0;
                    if (dump_req_i) begin
                        state_q <= DUMP_SCAN;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                    end
                end

                DUMP_SCAN: begin
                    // Index only moves on an accepted beat, so the presented
                    // index is stable while the consumer stalls.
                    if (valid_q && dump_ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= DUMP_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end

                DUMP_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= DUMP_IDLE;
                end

                default: begin
                    state_q <= DUMP_IDLE;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_valid_o = valid_q;
    assign dump_idx_o   = idx_q;
    assign dump_done_o  = done_q;

endmodule

// File: rtl/reg_file.sv
// ============================================================================
// reg_file
// ----------------------------------------------------------------------------
// RV32 integer register file: two combinational read ports, one write port,
// x0 hard-wired to zero, write-to-read bypass, an out-of-range address error
// flag and a valid/ready dump stream that walks every register.
//
// Ports
//   clk                 : clock, all state changes on the rising edge
//   reset_n             : synchronous active-low reset, clears all registers
//   load_pc_reg_addr1/2 : read addresses from ID (full 32-bit)
//   load_pc_reg_value1/2: read data to ID, zero-cycle latency
//   write_pc_reg_en     : write strobe
//   write_pc_reg_addr   : write address from ID (full 32-bit)
//   write_pc_reg_value  : write data
//   addr_err            : registered, high the cycle after an out-of-range
//                         write or out-of-range read address
//   dump_req            : start a full-register dump
//   dump_valid/ready    : dump stream handshake
//   dump_idx/dump_data  : presented register index and its live value
//   dump_done           : one-cycle pulse after the last beat is accepted
// ============================================================================
module reg_file
    import rv32_pkg::*;
#(
    parameter int XLEN    = rv32_pkg::XLEN,
    parameter int REG_CNT = rv32_pkg::REG_CNT
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] load_pc_reg_addr1,
    input  logic [ADDR_W-1:0] load_pc_reg_addr2,
    output logic [XLEN-1:0]   load_pc_reg_value1,
    output logic [XLEN-1:0]   load_pc_reg_value2,

    input  logic              write_pc_reg_en,
    input  logic [ADDR_W-1:0] write_pc_reg_addr,
    input  logic [XLEN-1:0]   write_pc_reg_value,

    output logic              addr_err,

    input  logic              dump_req,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [REG_AW-1:0] dump_idx,
    output logic [XLEN-1:0]   dump_data,
    output logic              dump_done
);

    logic [XLEN-1:0]   regs_q [REG_CNT];
    logic              addr_err_q;
    logic              addr_err_d;
    logic              wr_ok;
    logic [REG_AW-1:0] wr_idx;

    // ------------------------------------------------------------------
    // Write qualification: x0 and out-of-range targets are silently
    // dropped (the latter still raises addr_err).
    // ------------------------------------------------------------------
    assign wr_ok  = write_pc_reg_en
                  && addr_in_range(write_pc_reg_addr, REG_CNT)
                  && (write_pc_reg_addr != '0);
    assign wr_idx = write_pc_reg_addr[REG_AW-1:0];

    // Live value of one register as seen this cycle: zero for x0 and
    // out-of-range addresses, the in-flight write data when it targets the
    // same register, otherwise the stored value.  The full-width compare
    // keeps an out-of-range write from aliasing onto a low register.
    function automatic logic [XLEN-1:0] read_value(input logic [ADDR_W-1:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (addr_in_range(addr, REG_CNT) && (addr != '0)) begin
            if (wr_ok && (addr == write_pc_reg_addr)) begin
                val = write_pc_reg_value;
            end else begin
                val = regs_q[addr[REG_AW-1:0]];
            end
        end
        return val;
    endfunction

    // NOTE: each combinational output gets a default before any condition so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_pc_reg_value1 = '0;
        load_pc_reg_value2 = '0;
        dump_data          = '0;
        load_pc_reg_value1 = read_value(load_pc_reg_addr1);
        load_pc_reg_value2 = read_value(load_pc_reg_addr2);
        dump_data          = read_value(ADDR_W'(dump_idx));
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: this array is built from flops, so clearing it on reset is
    // legal; a RAM-backed register file could not be reset like this.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_idx] <= write_pc_reg_value;
        end
    end

    // ------------------------------------------------------------------
    // Address error: read ports have no enable, so an out-of-range address
    // on either port counts as an out-of-range read.
    // ------------------------------------------------------------------
    assign addr_err_d = (write_pc_reg_en && !addr_in_range(write_pc_reg_addr, REG_CNT))
                      || !addr_in_range(load_pc_reg_addr1, REG_CNT)
                      || !addr_in_range(load_pc_reg_addr2, REG_CNT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;

    // ------------------------------------------------------------------
    // Dump sequencer
    // ------------------------------------------------------------------
    reg_dump_fsm #(
        .REG_CNT (REG_CNT)
    ) u_dump_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .dump_req_i   (dump_req),
        .dump_ready_i (dump_ready),
        .dump_valid_o (dump_valid),
        .dump_idx_o   (dump_idx),
        .dump_done_o  (dump_done)
    );

endmodule

// File: tb/tb_reg_file.sv
// ============================================================================
// tb_reg_file
// ----------------------------------------------------------------------------
// Directed stimulus for reg_file.  Stimulus drives inputs 1 time unit after
// each rising edge and queues the values it expects to see in that cycle;
// a monitor on the falling edge pops and compares them.  Dump beats are
// checked against a separate queue whenever dump_valid && dump_ready.
// ============================================================================
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] load_pc_reg_addr1;
    logic [31:0] load_pc_reg_addr2;
    logic [31:0] load_pc_reg_value1;
    logic [31:0] load_pc_reg_value2;
    logic        write_pc_reg_en;
    logic [31:0] write_pc_reg_addr;
    logic [31:0] write_pc_reg_value;
    logic        addr_err;
    logic        dump_req;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_done;

    reg_file #(
        .XLEN    (32),
        .REG_CNT (32)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .load_pc_reg_addr1  (load_pc_reg_addr1),
        .load_pc_reg_addr2  (load_pc_reg_addr2),
        .load_pc_reg_value1 (load_pc_reg_value1),
        .load_pc_reg_value2 (load_pc_reg_value2),
        .write_pc_reg_en    (write_pc_reg_en),
        .write_pc_reg_addr  (write_pc_reg_addr),
        .write_pc_reg_value (write_pc_reg_value),
        .addr_err           (addr_err),
        .dump_req           (dump_req),
        .dump_valid         (dump_valid),
        .dump_ready         (dump_ready),
        .dump_idx           (dump_idx),
        .dump_data          (dump_data),
        .dump_done          (dump_done)
    );

    typedef enum {S_V1, S_V2, S_ERR, S_VALID, S_DONE, S_IDX, S_DATA} sig_e;

    typedef struct {
        int unsigned cyc;
        sig_e        sig;
        logic [31:0] exp;
        string       name;
    } chk_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    chk_t        chk_q[$];
    beat_t       beat_q[$];
    int unsigned cyc      = 0;
    int          total    = 0;
    int          bad      = 0;
    int          done_cnt = 0;
    logic [31:0] dump_exp [32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            S_V1:    return load_pc_reg_value1;
            S_V2:    return load_pc_reg_value2;
            S_ERR:   return {31'd0, addr_err};
            S_VALID: return {31'd0, dump_valid};
            S_DONE:  return {31'd0, dump_done};
            S_IDX:   return {27'd0, dump_idx};
            S_DATA:  return dump_data;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push_chk(input sig_e s, input logic [31:0] exp, input string name);
        chk_q.push_back('{cyc, s, exp, name});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares queued expectations for the current cycle and every
    // accepted dump beat.
    always @(negedge clk) begin
        beat_t b;
        chk_t  c;
        if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
            if (beat_q.size() == 0) begin
                check("dump_unexpected_beat", {27'd0, dump_idx}, 32'hFFFF_FFFF);
            end else begin
                b = beat_q.pop_front();
                check($sformatf("dump_idx[%0d]", b.idx), {27'd0, dump_idx}, {27'd0, b.idx});
                check($sformatf("dump_data[%0d]", b.idx), dump_data, b.data);
            end
        end
        if (dump_done === 1'b1) done_cnt++;
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c = chk_q.pop_front();
            check(c.name, sample(c.sig), c.exp);
        end
    end

    initial begin
        reset_n            = 1'b0;
        write_pc_reg_en    = 1'b1;
        write_pc_reg_addr  = 32'd3;
        write_pc_reg_value = 32'h77;
        load_pc_reg_addr1  = 32'd3;
        load_pc_reg_addr2  = 32'd20;
        dump_req           = 1'b0;
        dump_ready         = 1'b0;

        // Reset with a write presented: the write must be dropped.
        step();
        step();
        reset_n         = 1'b1;
        write_pc_reg_en = 1'b0;
        push_chk(S_V1, 32'd0, "rst_write_dropped_x3");
        push_chk(S_V2, 32'd0, "rst_x20_zero");
        push_chk(S_ERR, 32'd0, "rst_addr_err");
        push_chk(S_VALID, 32'd0, "rst_dump_valid");
        push_chk(S_DONE, 32'd0, "rst_dump_done");

        // ADDI operand case: write x20=8, read it back next cycle.
        step();
        write_pc_reg_en    = 1'b1;
        write_pc_reg_addr  = 32'd20;
        write_pc_reg_value = 32'd8;
        load_pc_reg_addr1  = 32'd1;
        load_pc_reg_addr2  = 32'd2;
        push_chk(S_V1, 32'd0, "x1_zero");
        step();
        write_pc_reg_en   = 1'b0;
        load_pc_reg_addr1 = 32'd20;
        push_chk(S_V1, 32'd8, "x20_after_write");

        // Bypass: write x12=15 while both ports read x12.
        step();
        write_pc_reg_en    = 1'b1;
        write_pc_reg_addr  = 32'd12;
        write_pc_reg_value = 32'd15;
        load_pc_reg_addr1  = 32'd12;
        load_pc_reg_addr2  = 32'd12;
        push_chk(S_V2, 32'd15, "bypass_v2_x12");
        push_chk(S_V1, 32'd15, "bypass_v1_x12");
        step();
        write_pc_reg_en = 1'b0;
        push_chk(S_V2, 32'd15, "stored_v2_x12");
        push_chk(S_V1, 32'd15, "stored_v1_x12");

        // x0 write is ignored and never bypassed.
        step();
        write_pc_reg_en    = 1'b1;
        write_pc_reg_addr  = 32'd0;
        write_pc_reg_value = 32'hDEAD_BEEF;
        load_pc_reg_addr1  = 32'd0;
        load_pc_reg_addr2  = 32'd0;
        push_chk(S_V1, 32'd0, "x0_no_bypass_v1");
        push_chk(S_V2, 32'd0, "x0_no_bypass_v2");
        step();
        write_pc_reg_en = 1'b0;
        push_chk(S_V1, 32'd0, "x0_stays_zero");
        push_chk(S_ERR, 32'd0, "x0_write_no_err");

        // Out-of-range write to 40: error next cycle, nothing changes.
        step();
        write_pc_reg_en    = 1'b1;
        write_pc_reg_addr  = 32'd40;
        write_pc_reg_value = 32'h1234;
        load_pc_reg_addr1  = 32'd20;
        load_pc_reg_addr2  = 32'd12;
        push_chk(S_V1, 32'd8, "oob_wr_x20_intact");
        step();
        write_pc_reg_en   = 1'b0;
        load_pc_reg_addr1 = 32'd8;
        push_chk(S_ERR, 32'd1, "oob_write_err");
        push_chk(S_V1, 32'd0, "oob_write_no_alias_x8");
        push_chk(S_V2, 32'd15, "oob_write_x12_intact");
        step();
        load_pc_reg_addr1 = 32'd33;
        push_chk(S_ERR, 32'd0, "err_clears");
        push_chk(S_V1, 32'd0, "oob_read1_zero");
        step();
        load_pc_reg_addr1 = 32'd20;
        push_chk(S_ERR, 32'd1, "oob_read1_err");
        step();
        load_pc_reg_addr2 = 32'd64;
        push_chk(S_ERR, 32'd0, "err_clears_2");
        push_chk(S_V2, 32'd0, "oob_read2_zero");
        step();
        load_pc_reg_addr2 = 32'd12;
        push_chk(S_ERR, 32'd1, "oob_read2_err");

        // Preload x5=5, then dump.
        step();
        write_pc_reg_en    = 1'b1;
        write_pc_reg_addr  = 32'd5;
        write_pc_reg_value = 32'd5;
        push_chk(S_ERR, 32'd0, "preload_no_err");
        step();
        write_pc_reg_en   = 1'b0;
        dump_req          = 1'b1;
        load_pc_reg_addr1 = 32'd5;
        push_chk(S_V1, 32'd5, "x5_preloaded");
        push_chk(S_VALID, 32'd0, "idle_before_req");

        step();
        dump_req   = 1'b0;
        dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) dump_exp[i] = 32'd0;
        dump_exp[5]  = 32'd5;
        dump_exp[12] = 32'd15;
        dump_exp[20] = 32'd8;
        dump_exp[30] = 32'h0000_ABCD;  // written live during the stall
        dump_exp[31] = 32'h0000_0031;  // written in its own presenting cycle
        for (int i = 0; i < 32; i++) beat_q.push_back('{5'(i), dump_exp[i]});
        push_chk(S_VALID, 32'd1, "scan_valid");
        push_chk(S_IDX, 32'd0, "scan_first_idx");

        repeat (5) step();
        dump_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            dump_req           = (h == 1);
            write_pc_reg_en    = (h == 1);
            write_pc_reg_addr  = 32'd30;
            write_pc_reg_value = 32'h0000_ABCD;
            push_chk(S_VALID, 32'd1, $sformatf("stall%0d_valid", h));
            push_chk(S_IDX, 32'd5, $sformatf("stall%0d_idx", h));
            push_chk(S_DATA, 32'd5, $sformatf("stall%0d_data", h));
            step();
        end
        dump_req        = 1'b0;
        write_pc_reg_en = 1'b0;
        dump_ready      = 1'b1;

        repeat (26) step();
        write_pc_reg_en    = 1'b1;
        write_pc_reg_addr  = 32'd31;
        write_pc_reg_value = 32'h0000_0031;
        load_pc_reg_addr1  = 32'd31;
        push_chk(S_IDX, 32'd31, "last_idx_presented");
        push_chk(S_V1, 32'h0000_0031, "bypass_v1_x31");
        step();
        write_pc_reg_en = 1'b0;
        push_chk(S_DONE, 32'd1, "done_pulse");
        push_chk(S_VALID, 32'd0, "done_valid_low");
        step();
        load_pc_reg_addr1 = 32'd30;
        load_pc_reg_addr2 = 32'd31;
        push_chk(S_DONE, 32'd0, "done_one_cycle");
        push_chk(S_VALID, 32'd0, "back_to_idle");
        push_chk(S_V1, 32'h0000_ABCD, "x30_live_write");
        push_chk(S_V2, 32'h0000_0031, "x31_stored");

        // Second dump, aborted by reset while idx 10 is presented.
        step();
        dump_req   = 1'b1;
        dump_ready = 1'b0;
        step();
        dump_req   = 1'b0;
        dump_ready = 1'b1;
        for (int i = 0; i < 10; i++) beat_q.push_back('{5'(i), (i == 5) ? 32'd5 : 32'd0});
        repeat (10) step();
        dump_ready         = 1'b0;
        reset_n            = 1'b0;
        write_pc_reg_en    = 1'b1;
        write_pc_reg_addr  = 32'd7;
        write_pc_reg_value = 32'h7777;
        push_chk(S_VALID, 32'd1, "abort_valid_before");
        push_chk(S_IDX, 32'd10, "abort_at_idx10");
        step();
        reset_n           = 1'b1;
        write_pc_reg_en   = 1'b0;
        load_pc_reg_addr1 = 32'd5;
        load_pc_reg_addr2 = 32'd30;
        push_chk(S_VALID, 32'd0, "abort_valid_low");
        push_chk(S_DONE, 32'd0, "abort_no_done");
        push_chk(S_V1, 32'd0, "abort_x5_cleared");
        push_chk(S_V2, 32'd0, "abort_x30_cleared");
        step();
        push_chk(S_VALID, 32'd0, "idle_after_abort");
        push_chk(S_DONE, 32'd0, "no_late_done");
        for (int i = 0; i < 32; i++) begin
            load_pc_reg_addr1 = i;
            push_chk(S_V1, 32'd0, $sformatf("post_rst_x%0d", i));
            step();
        end

        repeat (3) step();
        check("done_pulse_count", done_cnt, 32'd1);
        check("beats_outstanding", beat_q.size(), 32'd0);
        check("checks_outstanding", chk_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter REG_CNT, default 32, number of architectural registers.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port load_pc_reg_addr1, input, 32, read port 1 address from ID.
REQ-006 SHALL have port load_pc_reg_addr2, input, 32, read port 2 address from ID.
REQ-007 SHALL have port load_pc_reg_value1, output, XLEN, read port 1 data to ID.
REQ-008 SHALL have port load_pc_reg_value2, output, XLEN, read port 2 data to ID.
REQ-009 SHALL have port write_pc_reg_en, input, 1, write strobe.
REQ-010 SHALL have port write_pc_reg_addr, input, 32, write address from ID.
REQ-011 SHALL have port write_pc_reg_value, input, XLEN, write data from ID.
REQ-012 SHALL have port addr_err, output, 1, registered; high one cycle after any out-of-range access.
REQ-013 SHALL have port dump_req, input, 1, start full-register dump.
REQ-014 SHALL have ports dump_valid (output, 1), dump_ready (input, 1), dump_idx (output, 5) and dump_data (output, XLEN); these form the dump stream.
REQ-015 SHALL have port dump_done, output, 1, one-cycle pulse after the last entry is accepted.

Function
REQ-016 SHALL decode addresses 0..REG_CNT-1 as valid; any value >= REG_CNT is out of range.
REQ-017 SHALL return read data combinationally (zero-cycle latency) on both read ports.
REQ-018 SHALL return 0 for reads of x0 and for out-of-range reads.
REQ-019 SHALL commit writes on the clock edge when write_pc_reg_en=1, the address is in range, and the address is nonzero.
REQ-020 SHALL ignore writes to x0 and to out-of-range addresses; an out-of-range write, or a read on either port while that port's address is out of range, sets addr_err=1 on the next cycle.
REQ-021 SHALL bypass: when a write is enabled and valid in the same cycle and its address matches a read address, that read port returns write_pc_reg_value.
REQ-022 SHALL serve reads on both ports to the same address independently, with identical data.
REQ-023 SHALL implement the dump FSM with states IDLE, SCAN and DONE.
REQ-024 IDLE->SCAN on dump_req=1; idx := 0.
REQ-025 In SCAN, SHALL hold dump_valid=1 and present dump_idx=idx and dump_data=regs[idx], with bypass applied.
REQ-026 In SCAN, SHALL advance idx only when dump_valid and dump_ready are both high; dump_idx and dump_data stay stable while dump_ready=0.
REQ-027 SHALL go SCAN->DONE when idx=REG_CNT-1 is accepted; DONE asserts dump_done for one cycle, then returns to IDLE.
REQ-028 SHALL ignore dump_req outside IDLE (no restart or queueing).
REQ-029 SHALL allow writes to proceed during SCAN; the dump shows the live value at the time of the presenting cycle.

Reset
REQ-030 When reset_n=0 at a clock edge, SHALL clear every register to 0.
REQ-031 On the same reset edge, SHALL force the FSM to IDLE, idx=0, dump_valid=0, dump_done=0 and addr_err=0.
REQ-032 Reset asserted mid-SCAN SHALL abort the dump without a dump_done pulse.
REQ-033 Writes presented during the reset cycle SHALL be dropped.

Structure
REQ-034 SHALL place XLEN, REG_CNT, REG_AW=5 and the dump FSM state enum in shared package rv32_pkg, reused by ID.
REQ-035 SHALL implement the dump FSM as sub-module reg_dump_fsm; the storage array and bypass stay in reg_file.

Verification
REQ-036 Reset, then read addr1=20 -> value1=0; write x20=8, then next cycle read addr1=20 -> value1=8 (ADDI operand case).
REQ-037 Write x12=15 with addr2=12 in the same cycle -> value2=15 via bypass; next cycle -> 15 from storage.
REQ-038 Write x0=0xDEADBEEF -> reads of x0 return 0; write addr=40 -> addr_err=1 one cycle later and no register changes.
REQ-039 Preload x5=5, pulse dump_req, hold dump_ready=0 for 3 cycles at idx 5 -> dump_idx and dump_data stay stable; dump completes 32 entries, then dump_done=1 for exactly one cycle.
REQ-040 Deassert reset_n during SCAN at idx 10 -> next cycle FSM in IDLE, dump_valid=0, no dump_done, and all registers read 0.
